vector_load_packer: RTL

Writer-side companion of the 2-entry x 64-bit vector register file. It fetches 8 consecutive bytes from byte-wide data memory, one outstanding read at a time. It packs the bytes into one 64-bit vector and issues a single write (WE/WD/destination index) into the register file. It sits between the vector-load control path and the register file write port.

---
 rtl/vec_pkg.sv | 20 ++
 rtl/vector_load_packer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector load path.
//   LANES, LANE_W, VEC_W : vector geometry (8 byte lanes, 64-bit vector)
//   vreg_idx_t           : vector register index (two registers)
//   vlp_state_t          : vector_load_packer FSM states
package vec_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned VEC_W  = LANES * LANE_W;

    typedef logic [0:0] vreg_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } vlp_state_t;

endpackage

// File: rtl/vector_load_packer.sv
// Vector load packer: fetches LANES consecutive bytes from byte-wide data memory (one
// outstanding read at a time), packs them little-endian into one vector and issues a
// single register-file write.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : load request, honoured only while idle
//   base_addr, dest_reg   : lane-0 byte address and destination register, latched on start
//   mem_rd_en, mem_addr   : one-cycle read request per lane, address = base + lane
//   mem_rdata, mem_rvalid : read response, accepted only while waiting for it
//   rf_we, rf_wd, rf_dest : register-file write port, held for the whole write cycle
//   busy                  : high whenever not idle
//   done                  : one-cycle pulse coincident with rf_we
module vector_load_packer
    import vec_pkg::*;
#(
    parameter int unsigned LANES  = vec_pkg::LANES,
    parameter int unsigned LANE_W = vec_pkg::LANE_W,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  vreg_idx_t               dest_reg,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [LANE_W-1:0]       mem_rdata,
    input  logic                    mem_rvalid,
    output logic                    rf_we,
    output logic [LANES*LANE_W-1:0] rf_wd,
    output vreg_idx_t               rf_dest,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned VW = LANES * LANE_W;
    localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

    vlp_state_t        state_q, state_d;
    logic [CW-1:0]     lane_q, lane_d;
    logic [VW-1:0]     buf_q, buf_d;
    logic [ADDR_W-1:0] base_q, base_d;
    vreg_idx_t         dest_q, dest_d;

    // Output registers, loaded from the next-state values so every output is a flop.
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rf_we_q, rf_we_d;
    logic [VW-1:0]     rf_wd_q, rf_wd_d;
    vreg_idx_t         rf_dest_q, rf_dest_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        base_d  = base_q;
        dest_d  = dest_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    lane_d  = '0;
                    buf_d   = '0;
                    base_d  = base_addr;
                    dest_d  = dest_reg;
                end
            end
            REQ: begin
                // Any rvalid seen here belongs to no request of ours and is dropped.
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    buf_d[lane_q*LANE_W +: LANE_W] = mem_rdata;
                    if (lane_q == CW'(LANES - 1)) begin
                        state_d = WRITE;
                    end else begin
                        lane_d  = lane_q + CW'(1);
                        state_d = REQ;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_rd_en_d = (state_d == REQ);
        mem_addr_d  = (state_d == REQ) ? base_d + ADDR_W'(lane_d) : '0;
        rf_we_d     = (state_d == WRITE);
        rf_wd_d     = (state_d == WRITE) ? buf_d : '0;
        rf_dest_d   = (state_d == WRITE) ? dest_d : '0;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            buf_q       <= '0;
            base_q      <= '0;
            dest_q      <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_wd_q     <= '0;
            rf_dest_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            base_q      <= base_d;
            dest_q      <= dest_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            rf_we_q     <= rf_we_d;
            rf_wd_q     <= rf_wd_d;
            rf_dest_q   <= rf_dest_d;
            busy_q      <= busy_d;
        end
    end

    // The register file captures on the falling edge inside the WRITE cycle, before the
    // rising edge that would apply reset. Masking with reset keeps a reset that overlaps
    // WRITE from committing the vector.
    assign rf_we     = rf_we_q & ~reset;
    assign done      = rf_we_q & ~reset;
    assign rf_wd     = rf_wd_q;
    assign rf_dest   = rf_dest_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;

endmodule
